// File: rtl/as_mul_core_if.sv
// rtl/as_mul_core_if.sv - operand/result bundle for the complex arithmetic core
interface as_mul_core_if #(
  parameter int PART_LEN = 8
);
  logic                    in_valid;
  logic [2*PART_LEN-1:0]   a;
  logic [2*PART_LEN-1:0]   b;
  logic [1:0]              control_sig;
  logic [2*PART_LEN-1:0]   res;
  logic                    out_valid;

  modport master (
    output in_valid, a, b, control_sig,
    input  res, out_valid
  );

  modport slave (
    input  in_valid, a, b, control_sig,
    output res, out_valid
  );
endinterface

// File: rtl/as_mul_core.sv
// rtl/as_mul_core.sv - registered complex add/sub/multiply core
module as_mul_core #(
  parameter int PART_LEN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  as_mul_core_if.slave  bus
);
  localparam int W = 2 * PART_LEN;

  logic signed [PART_LEN-1:0] a_re, a_im, b_re, b_im;
  logic signed [W-1:0]        a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [W-1:0]        p_rr, p_ii, p_ri, p_ir;
  logic        [PART_LEN-1:0] as_re, as_im, mul_re, mul_im;
  logic        [W-1:0]        result;
  logic                       opp, asn;

  assign a_re = bus.a[W-1:PART_LEN];
  assign a_im = bus.a[PART_LEN-1:0];
  assign b_re = bus.b[W-1:PART_LEN];
  assign b_im = bus.b[PART_LEN-1:0];
  assign opp  = bus.control_sig[1];
  assign asn  = bus.control_sig[0];

  assign as_re = asn ? PART_LEN'({a_re[PART_LEN-1], a_re} - {b_re[PART_LEN-1], b_re})
                     : PART_LEN'({a_re[PART_LEN-1], a_re} + {b_re[PART_LEN-1], b_re});
  assign as_im = asn ? PART_LEN'({a_im[PART_LEN-1], a_im} - {b_im[PART_LEN-1], b_im})
                     : PART_LEN'({a_im[PART_LEN-1], a_im} + {b_im[PART_LEN-1], b_im});

  // Sign-extend to product width so each product is exact before truncation.
  assign a_re_x = {{PART_LEN{a_re[PART_LEN-1]}}, a_re};
  assign a_im_x = {{PART_LEN{a_im[PART_LEN-1]}}, a_im};
  assign b_re_x = {{PART_LEN{b_re[PART_LEN-1]}}, b_re};
  assign b_im_x = {{PART_LEN{b_im[PART_LEN-1]}}, b_im};

  assign p_rr = a_re_x * b_re_x;
  assign p_ii = a_im_x * b_im_x;
  assign p_ri = a_re_x * b_im_x;
  assign p_ir = a_im_x * b_re_x;

  assign mul_re = PART_LEN'({p_rr[W-1], p_rr} - {p_ii[W-1], p_ii});
  assign mul_im = PART_LEN'({p_ri[W-1], p_ri} + {p_ir[W-1], p_ir});

  assign result = opp ? {as_re, as_im} : {mul_re, mul_im};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.res <= result;
      end
    end
  end
endmodule

// File: tb/tb_as_mul_core.sv
// tb/tb_as_mul_core.sv - self-checking bench for as_mul_core
module tb_as_mul_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_res = 16'h0000;
  logic        exp_valid = 1'b0;

  as_mul_core_if #(.PART_LEN(8)) bus ();

  as_mul_core #(.PART_LEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer complex arithmetic, keep the low byte of each part.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] c);
    int ar, ai, br, bi, re, im;
    logic [7:0] xr, xi, yr, yi;
    xr = x[15:8]; xi = x[7:0]; yr = y[15:8]; yi = y[7:0];
    ar = int'($signed(xr)); ai = int'($signed(xi));
    br = int'($signed(yr)); bi = int'($signed(yi));
    if (c[1]) begin
      re = c[0] ? ar - br : ar + br;
      im = c[0] ? ai - bi : ai + bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    return {re[7:0], im[7:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                      input logic [1:0] c);
    bus.in_valid    = v;
    bus.a           = ta;
    bus.b           = tb;
    bus.control_sig = c;
    if (v) exp_res = model(ta, tb, c);
    exp_valid = v;
    @(posedge clk);
    #1;
    // Perturb inputs between edges; must not disturb the registered result.
    bus.a = ~ta;
    bus.control_sig = ~c;
    @(negedge clk);
    check("res", bus.res, exp_res);
    check("out_valid", {15'd0, bus.out_valid}, {15'd0, exp_valid});
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.control_sig = 2'b00;
    #1;
    check("reset_res", bus.res, 16'h0000);
    check("reset_valid", {15'd0, bus.out_valid}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 16'h1111, 16'h2222, 2'b10);
    check("idle_after_reset", {15'd0, bus.out_valid}, 16'h0000);

    step(1'b1, 16'h0302, 16'h0104, 2'b10);
    check("add_const", bus.res, 16'h0406);
    step(1'b1, 16'h0302, 16'h0104, 2'b11);
    check("sub_const", bus.res, 16'h02FE);
    step(1'b1, 16'h0302, 16'h0104, 2'b00);
    check("mul_const", bus.res, 16'hFB0E);
    step(1'b1, 16'h0302, 16'h0104, 2'b01);
    check("mul_asn_ignored", bus.res, 16'hFB0E);
    step(1'b1, 16'h7F00, 16'h0100, 2'b10);
    check("add_wrap", bus.res, 16'h8000);
    step(1'b1, 16'h8000, 16'h8000, 2'b00);
    check("mul_wrap_min", bus.res, 16'h0000);
    step(1'b1, 16'hFFFF, 16'hFFFF, 2'b00);
    check("mul_neg_one", bus.res, 16'h0002);
    step(1'b0, 16'h0000, 16'h0000, 2'b10);
    check("hold_res", bus.res, 16'h0002);

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 2'($urandom));
    end

    // Asynchronous reset in the middle of a valid operation.
    bus.in_valid    = 1'b1;
    bus.a           = 16'h1234;
    bus.b           = 16'h5678;
    bus.control_sig = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_res", bus.res, 16'h0000);
    check("async_reset_valid", {15'd0, bus.out_valid}, 16'h0000);
    @(negedge clk);
    check("reset_discard_res", bus.res, 16'h0000);
    check("reset_discard_valid", {15'd0, bus.out_valid}, 16'h0000);
    rst_n = 1'b1;
    exp_res = 16'h0000;
    step(1'b0, 16'h1234, 16'h5678, 2'b00);
    check("post_reset_quiet", bus.res, 16'h0000);
    step(1'b1, 16'h0302, 16'h0104, 2'b10);
    check("post_reset_add", bus.res, 16'h0406);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
